// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-stage constants: instruction step, alignment and default boot address.
// Pure definitions; no logic, no timing.
package ifetch_queue_pkg;

    localparam int          PC_STEP          = 4;
    localparam int          INST_ALIGN_BITS  = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Occupancy counters need one extra bit so a full queue is distinguishable from empty.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Pointer-based FIFO with sync flush and occupancy count; head read is combinational.
// Push becomes visible at the head one edge later; caller must never push when full or pop when empty.
module fetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Sequential PC generator feeding a fixed one-cycle instruction memory into a decoupling queue.
// Request to head-valid takes two edges; requests stall on queue credit, redirects flush everything.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int               FQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic [XLEN-1:0]           imem_rdata,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [XLEN-1:0]           inst,
    output logic [XLEN-1:0]           inst_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int              CW         = cnt_width(FQ_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INST_ALIGN_BITS) - 1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic [CW:0]       credit_used;
    logic              fq_push;
    logic              fq_pop;
    logic [2*XLEN-1:0] fq_head_dat;
    logic [XLEN-1:0]   redirect_tgt;

    // An outstanding fetch already owns a slot, so it is counted against the queue depth.
    assign credit_used  = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q};
    assign imem_req     = rst_n && !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign redirect_tgt = redirect_pc & ~ALIGN_MASK;

    assign fq_push    = inflight_q && !kill_q && !redirect_valid;
    assign fq_pop     = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req;
        kill_d        = redirect_valid && inflight_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(PC_STEP);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fq_push),
        .push_dat_i ({inflight_pc_q, imem_rdata}),
        .pop_i      (fq_pop),
        .flush_i    (redirect_valid),
        .head_dat_o (fq_head_dat),
        .count_o    (fq_count)
    );

    assign inst_valid = (fq_count != '0);
    assign inst       = inst_valid ? fq_head_dat[XLEN-1:0]      : '0;
    assign inst_pc    = inst_valid ? fq_head_dat[2*XLEN-1:XLEN] : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam int          XW      = 64;
    localparam logic [63:0] W_RESET = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n, redirect_valid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, inst, inst_pc;
    logic        imem_req, inst_valid;
    logic [2:0]  fq_count;

    logic          w_rst_n, w_redirect_valid, w_inst_ready;
    logic [XW-1:0] w_redirect_pc, w_imem_rdata, w_imem_addr, w_inst, w_inst_pc;
    logic          w_imem_req, w_inst_valid;
    logic [1:0]    w_fq_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory: returns the address as data one cycle after the request.
    always @(posedge clk) imem_rdata   <= imem_addr;
    always @(posedge clk) w_imem_rdata <= w_imem_addr;

    ifetch_queue dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fq_count(fq_count)
    );

    ifetch_queue #(.XLEN(XW), .RESET_PC(W_RESET), .FQ_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .fq_count(w_fq_count)
    );

    // Holds reset for a cycle, then releases at a falling edge: the current cycle is cycle 0.
    task automatic start(input logic ready);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = ready;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
        checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fq_count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", inst_pc); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL c0_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h4) begin failures++; $display("FAIL c1 got=%b/%h exp=0/4", inst_valid, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(i*4) || inst !== 32'(i*4)) begin
                failures++; $display("FAIL stream%0d got=%b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst, i*4, i*4);
            end
        end
    endtask

    task automatic test_backpressure;
        start(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (fq_count !== 3'd3 || imem_req !== 1'b0) begin failures++; $display("FAIL bp_c4 got=%0d/%b exp=3/0", fq_count, imem_req); end
        @(negedge clk);
        checks++; if (fq_count !== 3'd4) begin failures++; $display("FAIL bp_c5 got=%0d exp=4", fq_count); end
        repeat (5) @(negedge clk);
        checks++; if (fq_count !== 3'd4 || imem_req !== 1'b0 || inst_pc !== 32'h0) begin failures++; $display("FAIL bp_c10 got=%0d/%b/%h exp=4/0/0", fq_count, imem_req, inst_pc); end
        inst_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(i*4)) begin failures++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, inst_valid, inst_pc, i*4); end
        end
    endtask

    task automatic test_redirect_inflight;
        start(1'b1);
        repeat (2) @(negedge clk);
        checks++; if (inst_pc !== 32'h0 || inst_valid !== 1'b1) begin failures++; $display("FAIL ri_pre got=%b/%h exp=1/0", inst_valid, inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ri_req got=%b exp=0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (fq_count !== 3'd0 || inst_valid !== 1'b0) begin failures++; $display("FAIL ri_flush got=%0d/%b exp=0/0", fq_count, inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL ri_addr got=%b/%h exp=1/100", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL ri_stale got=%b pc=%h exp=0", inst_valid, inst_pc); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin failures++; $display("FAIL ri_new got=%b/%h exp=1/100", inst_valid, inst_pc); end
        @(negedge clk);
        checks++; if (inst_pc !== 32'h104) begin failures++; $display("FAIL ri_next got=%h exp=104", inst_pc); end
    endtask

    task automatic test_redirect_align;
        start(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL al_addr got=%h exp=200", imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (inst_pc !== 32'h200 || inst !== 32'h200) begin failures++; $display("FAIL al_head got=%h/%h exp=200/200", inst_pc, inst); end
        @(negedge clk);
        checks++; if (inst_pc !== 32'h204) begin failures++; $display("FAIL al_next got=%h exp=204", inst_pc); end
    endtask

    task automatic test_flush_pop_full;
        start(1'b0);
        repeat (6) @(negedge clk);
        checks++; if (fq_count !== 3'd4 || inst_valid !== 1'b1) begin failures++; $display("FAIL fp_full got=%0d/%b exp=4/1", fq_count, inst_valid); end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (fq_count !== 3'd0 || inst_valid !== 1'b0 || imem_addr !== 32'h300) begin failures++; $display("FAIL fp_flush got=%0d/%b/%h exp=0/0/300", fq_count, inst_valid, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fp_gap got=%b pc=%h exp=0", inst_valid, inst_pc); end
        @(negedge clk);
        checks++; if (inst_pc !== 32'h300 || fq_count !== 3'd1) begin failures++; $display("FAIL fp_new got=%h/%0d exp=300/1", inst_pc, fq_count); end
        @(negedge clk);
        checks++; if (inst_pc !== 32'h304) begin failures++; $display("FAIL fp_next got=%h exp=304", inst_pc); end
    endtask

    task automatic test_back_to_back;
        start(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h400; #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bb_req1 got=%b exp=0", imem_req); end
        @(negedge clk);
        redirect_pc = 32'h500; #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL bb_req2 got=%b/%b exp=0/0", imem_req, inst_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (imem_addr !== 32'h500) begin failures++; $display("FAIL bb_addr got=%h exp=500", imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL bb_gap got=%b pc=%h exp=0", inst_valid, inst_pc); end
        @(negedge clk);
        checks++; if (inst_pc !== 32'h500) begin failures++; $display("FAIL bb_head got=%h exp=500", inst_pc); end
    endtask

    task automatic test_async_reset;
        start(1'b1);
        repeat (5) @(negedge clk);
        checks++; if (inst_pc !== 32'hC) begin failures++; $display("FAIL ar_pre got=%h exp=c", inst_pc); end
        rst_n = 1'b0; #1;
        checks++; if (inst_valid !== 1'b0 || fq_count !== 3'd0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL ar_clear got=%b/%0d/%b/%h exp=0/0/0/0", inst_valid, fq_count, imem_req, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL ar_ghost got=%b pc=%h exp=0", inst_valid, inst_pc); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL ar_restart got=%b/%h exp=1/0", inst_valid, inst_pc); end
    endtask

    task automatic test_wide_wrap;
        logic [XW-1:0] exp_pc [5];
        logic          exp_v  [5];
        exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_v[0] = 1'b1;
        exp_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC; exp_v[1] = 1'b1;
        exp_pc[2] = 64'h0;                   exp_v[2] = 1'b0;
        exp_pc[3] = 64'h0;                   exp_v[3] = 1'b1;
        exp_pc[4] = 64'h4;                   exp_v[4] = 1'b1;
        w_rst_n = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_inst_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (w_imem_addr !== W_RESET || w_fq_count !== 2'd0) begin failures++; $display("FAIL w_rst got=%h/%0d exp=%h/0", w_imem_addr, w_fq_count, W_RESET); end
        w_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (w_inst_valid !== exp_v[i] || w_inst_pc !== exp_pc[i]) begin
                failures++; $display("FAIL w_seq%0d got=%b/%h exp=%b/%h", i, w_inst_valid, w_inst_pc, exp_v[i], exp_pc[i]);
            end
            @(negedge clk);
        end
        w_rst_n = 1'b0; w_inst_ready = 1'b0;
        @(negedge clk);
        w_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (w_fq_count !== 2'd2 || w_imem_req !== 1'b0) begin failures++; $display("FAIL w_full got=%0d/%b exp=2/0", w_fq_count, w_imem_req); end
    endtask

    initial begin
        w_rst_n = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_inst_ready = 1'b0;
        test_reset;
        test_backpressure;
        test_redirect_inflight;
        test_redirect_align;
        test_flush_pop_full;
        test_back_to_back;
        test_async_reset;
        test_wide_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
